// File: rtl/alu_seq.sv
// Register-machine sequencer wrapped around an external combinational 4-bit ALU.
// Load-immediate completes in IDLE; operate runs IDLE -> EXEC -> RESP.
//
// state | meaning
// IDLE  | accept instruction; load-immediate writes here
// EXEC  | drive ALU from latched operands, capture result and flags
// RESP  | hold response until res_ready
module alu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_instr,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_op,
  output logic       alu_l,
  input  logic [3:0] alu_R,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_sign,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_flags,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  regs_q [4];
  logic [3:0]  regs_d [4];
  logic        l_q, l_d;
  logic [1:0]  aluop_q, aluop_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  ra_q, ra_d;
  logic [1:0]  rb_q, rb_d;
  logic [3:0]  res_data_q, res_data_d;
  logic [2:0]  flags_q, flags_d;

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    l_d        = l_q;
    aluop_d    = aluop_q;
    rd_d       = rd_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    res_data_d = res_data_q;
    flags_d    = flags_q;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    alu_A      = 4'h0;
    alu_B      = 4'h0;
    alu_op     = 2'b00;
    alu_l      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          if (in_instr[9]) begin
            regs_d[in_instr[5:4]] = in_instr[3:0];
          end else begin
            l_d     = in_instr[8];
            aluop_d = in_instr[7:6];
            rd_d    = in_instr[5:4];
            ra_d    = in_instr[3:2];
            rb_d    = in_instr[1:0];
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        // Operands come from the pre-write-back registers, so rd may alias ra/rb.
        alu_A          = regs_q[ra_q];
        alu_B          = regs_q[rb_q];
        alu_op         = aluop_q;
        alu_l          = l_q;
        regs_d[rd_q]   = alu_R;
        res_data_d     = alu_R;
        flags_d        = {alu_zero, alu_carry, alu_sign};
        state_d        = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'h0;
      l_q        <= 1'b0;
      aluop_q    <= 2'b00;
      rd_q       <= 2'b00;
      ra_q       <= 2'b00;
      rb_q       <= 2'b00;
      res_data_q <= 4'h0;
      flags_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      l_q        <= l_d;
      aluop_q    <= aluop_d;
      rd_q       <= rd_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      res_data_q <= res_data_d;
      flags_q    <= flags_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_flags = flags_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; the bench plays the ALU and queues expected responses.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_instr;
  logic [3:0] alu_A, alu_B;
  logic [1:0] alu_op;
  logic       alu_l;
  logic [3:0] alu_R;
  logic       alu_zero, alu_carry, alu_sign;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_flags;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_op    (alu_op),
    .alu_l     (alu_l),
    .alu_R     (alu_R),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_sign  (alu_sign),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] li(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction

  function automatic logic [9:0] opr(input logic l, input logic [1:0] op,
                                     input logic [1:0] rd, input logic [1:0] ra,
                                     input logic [1:0] rb);
    return {1'b0, l, op, rd, ra, rb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, {4'h0, dbg_data}, {4'h0, exp});
  endtask

  task automatic set_alu(input logic [3:0] r, input logic [2:0] f);
    alu_R = r;
    {alu_zero, alu_carry, alu_sign} = f;
  endtask

  // Waits (bounded) for a response and compares it with the oldest queued expectation.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   n = 0;
    while (!res_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {7'h0, res_valid}, 8'h01);
    chk({tag, "_sb_nonempty"}, {7'h0, (sb.size() != 0)}, 8'h01);
    if (res_valid && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, {4'h0, res_data}, {4'h0, e.d});
      chk({tag, "_flags"}, {5'h0, res_flags}, {5'h0, e.f});
    end
  endtask

  logic [3:0] burst_vals [4];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = li(2'd0, 4'hA);
    res_ready = 1'b0;
    dbg_sel   = 2'd0;
    set_alu(4'h0, 3'b000);

    // reset held two cycles with an instruction presented
    tick();
    chk("rst_in_ready_0", {7'h0, in_ready}, 8'h00);
    chk("rst_res_valid_0", {7'h0, res_valid}, 8'h00);
    tick();
    chk("rst_in_ready_1", {7'h0, in_ready}, 8'h00);
    chk("rst_res_valid_1", {7'h0, res_valid}, 8'h00);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {7'h0, in_ready}, 8'h01);
    chk("post_rst_alu_A", {4'h0, alu_A}, 8'h00);
    chk("post_rst_res_data", {4'h0, res_data}, 8'h00);
    for (int i = 0; i < 4; i++) chk_reg($sformatf("rst_r%0d", i), 2'(i), 4'h0);

    // load-immediate burst, one accept per cycle
    burst_vals[0] = 4'h5;
    burst_vals[1] = 4'h3;
    burst_vals[2] = 4'hF;
    burst_vals[3] = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = li(2'(i), burst_vals[i]);
      #1;
      chk($sformatf("li_ready_%0d", i), {7'h0, in_ready}, 8'h01);
      tick();
      chk_reg($sformatf("li_r%0d", i), 2'(i), burst_vals[i]);
    end
    in_valid = 1'b0;
    chk_reg("li_r0_kept", 2'd0, 4'h5);
    chk("li_no_resp", {7'h0, res_valid}, 8'h00);

    // operate r2 = alu(r0, r1)
    set_alu(4'h8, 3'b001);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = opr(1'b0, 2'b01, 2'd2, 2'd0, 2'd1);
    sb.push_back('{d: 4'h8, f: 3'b001});
    tick();
    in_valid = 1'b0;
    chk("op_alu_A", {4'h0, alu_A}, 8'h05);
    chk("op_alu_B", {4'h0, alu_B}, 8'h03);
    chk("op_alu_op", {6'h0, alu_op}, 8'h01);
    chk("op_alu_l", {7'h0, alu_l}, 8'h00);
    chk("op_exec_in_ready", {7'h0, in_ready}, 8'h00);
    chk("op_exec_no_resp", {7'h0, res_valid}, 8'h00);
    tick();
    chk("op_resp_T1", {7'h0, res_valid}, 8'h01);
    wait_resp("op");
    chk("op_resp_alu_A_idle", {4'h0, alu_A}, 8'h00);
    chk_reg("op_r2", 2'd2, 4'h8);
    tick();
    chk("op_done_valid", {7'h0, res_valid}, 8'h00);
    chk("op_done_ready", {7'h0, in_ready}, 8'h01);

    // response stall with a new instruction waiting
    set_alu(4'h2, 3'b010);
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = opr(1'b1, 2'b10, 2'd3, 2'd2, 2'd0);
    sb.push_back('{d: 4'h2, f: 3'b010});
    tick();
    chk("st_alu_A", {4'h0, alu_A}, 8'h08);
    chk("st_alu_B", {4'h0, alu_B}, 8'h05);
    chk("st_alu_op", {6'h0, alu_op}, 8'h02);
    chk("st_alu_l", {7'h0, alu_l}, 8'h01);
    in_instr = li(2'd1, 4'h7);
    tick();
    wait_resp("st");
    set_alu(4'hF, 3'b111);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("st_valid_%0d", k), {7'h0, res_valid}, 8'h01);
      chk($sformatf("st_data_%0d", k), {4'h0, res_data}, 8'h02);
      chk($sformatf("st_flags_%0d", k), {5'h0, res_flags}, 8'h02);
      chk($sformatf("st_in_ready_%0d", k), {7'h0, in_ready}, 8'h00);
      chk_reg($sformatf("st_r1_%0d", k), 2'd1, 4'h3);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("st_pre_xfer_ready", {7'h0, in_ready}, 8'h00);
    tick();
    chk("st_xfer_valid", {7'h0, res_valid}, 8'h00);
    chk("st_xfer_ready", {7'h0, in_ready}, 8'h01);
    chk_reg("st_r1_not_yet", 2'd1, 4'h3);
    tick();
    in_valid = 1'b0;
    chk_reg("st_r1_loaded", 2'd1, 4'h7);
    chk_reg("st_r3", 2'd3, 4'h2);

    // aliasing rd = ra = rb = r1
    set_alu(4'hE, 3'b001);
    in_valid = 1'b1;
    in_instr = opr(1'b0, 2'b00, 2'd1, 2'd1, 2'd1);
    sb.push_back('{d: 4'hE, f: 3'b001});
    tick();
    in_valid = 1'b0;
    chk("al_alu_A", {4'h0, alu_A}, 8'h07);
    chk("al_alu_B", {4'h0, alu_B}, 8'h07);
    chk_reg("al_r1_exec", 2'd1, 4'h7);
    tick();
    wait_resp("al");
    chk_reg("al_r1_after", 2'd1, 4'hE);
    tick();

    // reset while a response is pending
    set_alu(4'h9, 3'b100);
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = opr(1'b0, 2'b11, 2'd0, 2'd1, 2'd2);
    tick();
    in_valid = 1'b0;
    tick();
    chk("rr_valid_before", {7'h0, res_valid}, 8'h01);
    chk_reg("rr_r0_written", 2'd0, 4'h9);
    reset = 1'b1;
    tick();
    chk("rr_valid_after", {7'h0, res_valid}, 8'h00);
    chk("rr_in_ready_rst", {7'h0, in_ready}, 8'h00);
    reset = 1'b0;
    #1;
    chk("rr_res_data", {4'h0, res_data}, 8'h00);
    chk("rr_res_flags", {5'h0, res_flags}, 8'h00);
    chk("rr_in_ready", {7'h0, in_ready}, 8'h01);
    for (int i = 0; i < 4; i++) chk_reg($sformatf("rr_r%0d", i), 2'(i), 4'h0);

    // normal operate after reset
    in_valid = 1'b1;
    in_instr = li(2'd0, 4'h4);
    tick();
    in_instr = li(2'd1, 4'h6);
    tick();
    set_alu(4'h0, 3'b100);
    res_ready = 1'b1;
    in_instr  = opr(1'b1, 2'b11, 2'd2, 2'd0, 2'd1);
    sb.push_back('{d: 4'h0, f: 3'b100});
    tick();
    in_valid = 1'b0;
    chk("pr_alu_A", {4'h0, alu_A}, 8'h04);
    chk("pr_alu_B", {4'h0, alu_B}, 8'h06);
    chk("pr_alu_op", {6'h0, alu_op}, 8'h03);
    chk("pr_alu_l", {7'h0, alu_l}, 8'h01);
    tick();
    wait_resp("pr");
    tick();
    chk("pr_done_ready", {7'h0, in_ready}, 8'h01);
    chk("sb_drained", {7'h0, (sb.size() == 0)}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer that sits on the operand/opcode side of the 4-bit `alu` and turns it into a small register machine. It accepts 10-bit instructions over a valid/ready handshake and holds four 4-bit registers. For each operate instruction it drives the ALU's A, B, ALUop and l inputs, captures R and the zero/carry/sign flags, writes the result back, and presents it on a response handshake. It treats `alu` as a purely combinational external block whose outputs settle within one cycle.

## Interface

No parameters; all widths are fixed by the 4-bit ALU.

- `clk` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: instruction present.
- `in_ready` output 1: block can accept an instruction.
- `in_instr` input 10: instruction word (format in Operation).
- `alu_A` output 4: to ALU operand A.
- `alu_B` output 4: to ALU operand B.
- `alu_op` output 2: to ALU ALUop.
- `alu_l` output 1: to ALU l (0 = arithmetic, 1 = logic).
- `alu_R` input 4: ALU result.
- `alu_zero` input 1: ALU zero flag.
- `alu_carry` input 1: ALU carry flag.
- `alu_sign` input 1: ALU sign flag.
- `res_valid` output 1: response present.
- `res_ready` input 1: consumer takes the response.
- `res_data` output 4: result written to rd.
- `res_flags` output 3: {zero, carry, sign} captured with the result.
- `dbg_sel` input 2: register index for the debug read port.
- `dbg_data` output 4: combinational read of register `dbg_sel`.

## Operation

- **Instruction format:**
  - `in_instr[9]`: kind, 0 = operate, 1 = load-immediate.
  - Operate: `[8]` l, `[7:6]` ALUop, `[5:4]` rd, `[3:2]` ra, `[1:0]` rb.
  - Load-immediate: `[5:4]` rd, `[3:0]` imm; `[8:6]` are ignored.
- **Register file:** four 4-bit registers r0..r3.
- **Flag register:** 3 bits.
- **States:** IDLE, EXEC, RESP.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid` with load-immediate: rd ← imm at that edge. State stays IDLE. Flags unchanged. No response is produced.
  - On `in_valid` with operate: latch l, ALUop, rd, ra, rb and go to EXEC.
- **EXEC (exactly one cycle):**
  - Drive `alu_A` = r[ra], `alu_B` = r[rb], `alu_op` = ALUop, `alu_l` = l.
  - At the end of the cycle:
    - rd ← `alu_R`.
    - flags ← {`alu_zero`, `alu_carry`, `alu_sign`}.
    - `res_data` / `res_flags` registers ← the same values.
    - Go to RESP.
- **RESP:**
  - `res_valid` = 1; `res_data` and `res_flags` are held stable.
  - On `res_ready`, go to IDLE.
- **ALU drive outside EXEC:** `alu_A`, `alu_B`, `alu_op`, `alu_l` are all 0.
- **Operand aliasing:** ra, rb and rd may alias; operands are read in EXEC, before the write-back edge.
- **Arithmetic:** none inside this block. Results are taken verbatim from the ALU; 4-bit wrap-around is the ALU's concern.

## Timing

- **Reset values:**
  - All registers 0, flags 0, `res_data` 0, `res_flags` 0, state IDLE.
  - `res_valid` 0; all ALU drive outputs 0.
  - `in_ready` is forced 0 while `reset` is high and is 1 from the first cycle after reset deasserts.
- **Handshake rules:**
  - Transfer occurs on a rising edge where valid and ready are both high.
  - `in_valid` may drop without being accepted.
  - `res_valid`, once high, stays high with stable data until `res_ready`.
- **Operate latency:** accept at edge T → EXEC during cycle T..T+1 → `res_valid` high from edge T+1. If `res_ready` is held high, response transfer occurs at edge T+2 and `in_ready` is high again after T+2.
- **Operate throughput:** one operate per 3 cycles maximum.
- **Load-immediate timing:** one per cycle, back-to-back. A written value is visible on `dbg_data` and to a following operate's EXEC immediately after the write edge.
- **`in_ready` outside IDLE:** 0 in EXEC and RESP; instructions presented then are not accepted.
- **Debug port:** `dbg_data` is combinational and reflects the register state after the most recent edge.
- **Reset mid-operation (EXEC or RESP):** the operation is abandoned, no write-back and no response; everything returns to reset values on that edge.

## Test plan

- **Reset:**
  - Stimulus: hold `reset` for 2 cycles with `in_valid` = 1.
  - Required: `in_ready` = 0 and `res_valid` = 0 during reset; all `dbg_data` reads = 0 afterwards; nothing is written.
- **Load-immediate burst:**
  - Stimulus: back-to-back writes r0=0x5, r1=0x3, r2=0xF, r3=0x0 with `in_valid` continuous.
  - Required: one accept per cycle; `dbg_data` shows 5, 3, F, 0.
- **Operate:**
  - Stimulus: instruction l=0, ALUop=01, rd=2, ra=0, rb=1. Bench ALU returns R=0x8, zero=0, carry=0, sign=1.
  - Required: in EXEC, `alu_A`=5, `alu_B`=3, `alu_op`=01, `alu_l`=0.
  - Required: `res_valid` from edge T+1 with `res_data`=8 and `res_flags`=001; r2 = 8.
- **Response stall:**
  - Stimulus: hold `res_ready` = 0 for 4 cycles while presenting a new `in_valid`.
  - Required: `res_valid`, `res_data`, `res_flags` stay stable; `in_ready` = 0; the new instruction is accepted only after the response transfer.
- **Aliasing:**
  - Stimulus: rd=ra=rb=1 with r1=0x7; bench returns R=0xE.
  - Required: `alu_A` = `alu_B` = 7 in EXEC; r1 = E only after EXEC.
- **Reset during RESP:**
  - Stimulus: assert `reset` while `res_valid` = 1.
  - Required: `res_valid` = 0 on the next edge; registers and flags = 0; the next operate behaves normally.
